// File: rtl/door_plant_model.sv
// Behavioural door/motor plant: integrates ma/mc motor commands into a position,
// decodes limit switches and flags sticky conflict/stall/obstruction faults.
module door_plant_model #(
    parameter int POS_W     = 8,
    parameter int TRAVEL    = 20,
    parameter int STEP_DIV  = 4,
    parameter int STALL_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             ma,
    input  logic             mc,
    input  logic             obstruct,
    input  logic             clr_fault,
    output logic [POS_W-1:0] pos,
    output logic             la,
    output logic             lc,
    output logic             moving,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam int PW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
    localparam int SW = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
    localparam logic [POS_W-1:0] TRAVEL_P  = POS_W'(TRAVEL);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_CYC - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OPEN  = 3'd1;
    localparam logic [2:0] ST_CLOSE = 3'd2;
    localparam logic [2:0] ST_BLOCK = 3'd3;
    localparam logic [2:0] ST_CONF  = 3'd4;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [PW-1:0]    presc_q, presc_d, presc_eff;
    logic [SW-1:0]    stall_q, stall_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
    logic             dir_q, dir_d;
    logic             open_req, close_req, at_open, at_closed;
    logic [2:0]       st;

    assign open_req  = ma & ~mc;
    assign close_req = mc & ~ma;
    assign at_open   = (pos_q == TRAVEL_P);
    assign at_closed = (pos_q == '0);

    always_comb begin
        if (ma & mc)                                    st = ST_CONF;
        else if (open_req & ~at_open)                   st = ST_OPEN;
        else if (close_req & ~at_closed & ~obstruct)    st = ST_CLOSE;
        else if (open_req | close_req)                  st = ST_BLOCK;
        else                                            st = ST_IDLE;
    end

    // A reversal restarts the step prescaler rather than inheriting the old direction's count.
    assign presc_eff = (dir_q != (st == ST_CLOSE)) ? '0 : presc_q;

    always_comb begin
        pos_d   = pos_q;
        presc_d = presc_q;
        stall_d = stall_q;
        fault_d = fault_q;
        code_d  = code_q;
        dir_d   = dir_q;
        if (clr_fault) begin
            fault_d = 1'b0;
            code_d  = 2'b00;
            stall_d = '0;
            presc_d = '0;
        end else if (fault_q) begin
            presc_d = '0;
            stall_d = '0;
        end else begin
            case (st)
                ST_CONF: begin
                    fault_d = 1'b1;
                    code_d  = 2'b01;
                    presc_d = '0;
                    stall_d = '0;
                end
                ST_OPEN, ST_CLOSE: begin
                    stall_d = '0;
                    dir_d   = (st == ST_CLOSE);
                    if (presc_eff == PRESC_MAX) begin
                        presc_d = '0;
                        pos_d   = (st == ST_CLOSE) ? pos_q - 1'b1 : pos_q + 1'b1;
                    end else begin
                        presc_d = presc_eff + 1'b1;
                    end
                end
                ST_BLOCK: begin
                    presc_d = '0;
                    if (stall_q == STALL_MAX) begin
                        fault_d = 1'b1;
                        code_d  = (close_req & ~at_closed) ? 2'b11 : 2'b10;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                default: begin
                    presc_d = '0;
                    stall_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            presc_q <= '0;
            stall_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            dir_q   <= 1'b0;
        end else if (ena) begin
            pos_q   <= pos_d;
            presc_q <= presc_d;
            stall_q <= stall_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
        end
    end

    assign pos        = pos_q;
    assign la         = at_open;
    assign lc         = at_closed;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign moving     = ena & ~fault_q & ~clr_fault & ((st == ST_OPEN) | (st == ST_CLOSE));
endmodule

// File: tb/tb_door_plant_model.sv
// Randomised + directed closed-loop bench for door_plant_model with a queue-based scoreboard.
module tb_door_plant_model;
    localparam int POS_W = 8, TRAVEL = 20, STEP_DIV = 4, STALL_CYC = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ena = 1'b0, ma = 1'b0, mc = 1'b0, obstruct = 1'b0, clr_fault = 1'b0;
    logic [POS_W-1:0] pos;
    logic la, lc, moving, fault;
    logic [1:0] fault_code;

    door_plant_model #(.POS_W(POS_W), .TRAVEL(TRAVEL), .STEP_DIV(STEP_DIV), .STALL_CYC(STALL_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ma(ma), .mc(mc), .obstruct(obstruct),
        .clr_fault(clr_fault), .pos(pos), .la(la), .lc(lc), .moving(moving),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pos;
        logic       la, lc, moving, fault;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    bit done = 0;

    // Reference plant: position plus ticks accumulated toward the next step.
    int m_pos, m_ticks, m_stall, m_code, m_dir;
    bit m_fault;

    function automatic void m_reset();
        m_pos = 0; m_ticks = 0; m_stall = 0; m_fault = 0; m_code = 0; m_dir = 0;
    endfunction

    function automatic bit m_moving(bit en, bit a, bit c, bit ob, bit cl);
        bit go_open, go_close;
        go_open  = a && !c && m_pos < TRAVEL;
        go_close = c && !a && m_pos > 0 && !ob;
        return en && !m_fault && !cl && (go_open || go_close);
    endfunction

    function automatic void m_step(bit en, bit a, bit c, bit ob, bit cl);
        int d;
        if (!en) return;
        if (cl) begin
            m_fault = 0; m_code = 0; m_stall = 0; m_ticks = 0;
            return;
        end
        if (m_fault) begin m_ticks = 0; m_stall = 0; return; end
        if (a && c) begin
            m_fault = 1; m_code = 1; m_ticks = 0; m_stall = 0;
            return;
        end
        if (!a && !c) begin m_ticks = 0; m_stall = 0; return; end
        d = a ? 1 : -1;
        if ((d == 1 && m_pos < TRAVEL) || (d == -1 && m_pos > 0 && !ob)) begin
            if (d != m_dir) m_ticks = 0;
            m_dir = d;
            m_stall = 0;
            m_ticks++;
            if (m_ticks == STEP_DIV) begin m_pos += d; m_ticks = 0; end
        end else begin
            m_ticks = 0;
            m_stall++;
            if (m_stall == STALL_CYC) begin
                m_fault = 1;
                m_code = (d == -1 && m_pos > 0) ? 3 : 2;
                m_stall = 0;
            end
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show during it, then advance the model.
    task automatic step(bit en, bit a, bit c, bit ob, bit cl);
        exp_t e;
        @(negedge clk);
        ena = en; ma = a; mc = c; obstruct = ob; clr_fault = cl;
        e.pos = 8'(m_pos); e.la = (m_pos == TRAVEL); e.lc = (m_pos == 0);
        e.fault = m_fault; e.code = 2'(m_code);
        e.moving = m_moving(en, a, c, ob, cl);
        q.push_back(e);
        m_step(en, a, c, ob, cl);
    endtask

    task automatic hold(int n, bit en, bit a, bit c, bit ob, bit cl);
        for (int i = 0; i < n; i++) step(en, a, c, ob, cl);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pos", int'(pos), 0);
        chk("rst_lc", int'(lc), 1);
        chk("rst_la", int'(la), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_code", int'(fault_code), 0);
        m_reset();
        rst_n = 1'b1;
    endtask

    always begin
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pos", int'(pos), int'(e.pos));
            chk("la", int'(la), int'(e.la));
            chk("lc", int'(lc), int'(e.lc));
            chk("moving", int'(moving), int'(e.moving));
            chk("fault", int'(fault), int'(e.fault));
            chk("fault_code", int'(fault_code), int'(e.code));
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1);
        end
    end

    initial begin
        m_reset();
        #3;
        chk("init_pos", int'(pos), 0);
        chk("init_lc", int'(lc), 1);
        chk("init_la", int'(la), 0);
        chk("init_moving", int'(moving), 0);
        chk("init_fault", int'(fault), 0);
        @(negedge clk);
        rst_n = 1'b1;

        hold(80, 1, 1, 0, 0, 0);          // full open
        hold(5, 1, 1, 0, 0, 0);           // blocked at limit, below stall threshold
        hold(40, 1, 0, 1, 0, 0);          // close to 10
        hold(8, 1, 0, 1, 1, 0);           // obstructed, short of stall
        hold(6, 1, 0, 1, 0, 0);           // resumes
        hold(2, 1, 0, 0, 0, 0);
        hold(16, 1, 0, 1, 1, 0);          // obstruction stall -> code 11
        hold(3, 1, 1, 0, 0, 0);           // no motion while faulted
        hold(1, 1, 0, 0, 0, 1);
        hold(60, 1, 1, 0, 0, 0);          // reach open, stall at limit -> code 10
        hold(1, 1, 0, 0, 0, 1);
        hold(1, 1, 1, 1, 0, 0);           // conflict
        hold(2, 1, 0, 0, 0, 0);
        hold(1, 1, 1, 1, 0, 1);           // clear wins this edge
        hold(2, 1, 1, 1, 0, 0);           // re-faults
        hold(1, 1, 0, 0, 0, 1);
        hold(10, 0, 0, 1, 0, 0);          // disabled: frozen
        hold(54, 1, 0, 1, 0, 0);          // pos 7, two ticks into next step
        hold(1, 1, 0, 0, 0, 0);
        async_reset();
        hold(1, 1, 0, 0, 0, 0);
        hold(5, 1, 0, 1, 0, 0);           // close at 0 -> blocked at limit
        hold(1, 1, 0, 0, 0, 0);

        for (int s = 0; s < 400; s++) begin
            int len, cmd, r;
            bit ob, a, c;
            len = $urandom_range(1, 30);
            r = $urandom_range(0, 99);
            cmd = (r < 15) ? 0 : (r < 55) ? 1 : (r < 95) ? 2 : 3;
            a = (cmd == 1 || cmd == 3);
            c = (cmd == 2 || cmd == 3);
            ob = ($urandom_range(0, 3) == 0);
            if (cmd == 3) len = 1;
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 9) != 0, a, c, ob, $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) async_reset();
        end
        hold(2, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
